// File: rtl/wb_result_router.sv
// Routes one 8-bit result to the ALU latch, remainder register, BUS_1 driver or data-memory write port.
// Register sinks: 1 cycle. Memory: req/ack with timeout; in_ready is held low for the whole memory write.
module wb_result_router #(
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic [1:0]        in_dest,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [7:0]        alu_opnd,
  output logic              alu_load,
  output logic [7:0]        rem_reg,
  output logic              rem_load,
  output logic [7:0]        bus1_data,
  output logic              bus1_strobe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              mem_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             xfer;

  assign in_ready = (state == IDLE) && !reset;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      alu_opnd    <= '0;
      alu_load    <= 1'b0;
      rem_reg     <= '0;
      rem_load    <= 1'b0;
      bus1_data   <= '0;
      bus1_strobe <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      alu_load    <= 1'b0;
      rem_load    <= 1'b0;
      bus1_strobe <= 1'b0;
      mem_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            case (in_dest)
              2'b00: begin
                alu_opnd <= in_data;
                alu_load <= 1'b1;
              end
              2'b01: begin
                rem_reg  <= in_data;
                rem_load <= 1'b1;
              end
              2'b10: begin
                bus1_data   <= in_data;
                bus1_strobe <= 1'b1;
              end
              2'b11: begin
                mem_addr  <= in_addr;
                mem_wdata <= in_data;
                mem_req   <= 1'b1;
                busy      <= 1'b1;
                wait_cnt  <= '0;
                state     <= MEM_WAIT;
              end
            endcase
          end
        end
        MEM_WAIT: begin
          // ack takes priority over a timeout expiring on the same edge
          if (mem_ack) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (wait_cnt == CNT_LAST) begin
              mem_req <= 1'b0;
              busy    <= 1'b0;
              mem_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_result_router.sv
// Directed bench for wb_result_router: register sinks, memory ack, timeout, ack-at-expiry, reset mid-write.
module tb_wb_result_router;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic [7:0] in_addr;
  logic [7:0] alu_opnd;
  logic       alu_load;
  logic [7:0] rem_reg;
  logic       rem_load;
  logic [7:0] bus1_data;
  logic       bus1_strobe;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic       mem_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  wb_result_router #(.ADDR_W(8), .MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_addr    (in_addr),
    .alu_opnd   (alu_opnd),
    .alu_load   (alu_load),
    .rem_reg    (rem_reg),
    .rem_load   (rem_load),
    .bus1_data  (bus1_data),
    .bus1_strobe(bus1_strobe),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_err    (mem_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // advance one rising edge, then settle so outputs reflect that edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] d, input logic [7:0] v, input logic [7:0] a);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    in_addr  = a;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    in_addr  = '0;
    mem_ack  = 1'b0;
    tick();
    tick();
    check("ready_in_reset", in_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_alu_opnd", alu_opnd, 0);
    check("rst_rem_reg", rem_reg, 0);
    check("rst_bus1_data", bus1_data, 0);
    check("rst_strobes", {alu_load, rem_load, bus1_strobe}, 0);
    check("rst_mem", {mem_req, mem_err, busy}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_in_ready", in_ready, 1);

    // three register sinks back to back
    offer(2'b00, 8'h3C, 8'h00);
    tick();
    check("alu_opnd", alu_opnd, 8'h3C);
    check("alu_strobes", {alu_load, rem_load, bus1_strobe}, 3'b100);
    check("ready_after_alu", in_ready, 1);
    offer(2'b01, 8'h05, 8'h00);
    tick();
    check("rem_reg", rem_reg, 8'h05);
    check("rem_strobes", {alu_load, rem_load, bus1_strobe}, 3'b010);
    check("alu_hold", alu_opnd, 8'h3C);
    offer(2'b10, 8'hA7, 8'h00);
    tick();
    check("bus1_data", bus1_data, 8'hA7);
    check("bus1_strobes", {alu_load, rem_load, bus1_strobe}, 3'b001);
    check("ready_after_bus1", in_ready, 1);
    in_valid = 1'b0;
    tick();
    check("strobes_clear", {alu_load, rem_load, bus1_strobe}, 0);

    // consecutive same-dest strobe stays high
    offer(2'b00, 8'h11, 8'h00);
    tick();
    check("alu_first", alu_opnd, 8'h11);
    offer(2'b00, 8'h22, 8'h00);
    tick();
    check("alu_second", alu_opnd, 8'h22);
    check("alu_load_cont", alu_load, 1);
    in_valid = 1'b0;
    tick();
    check("alu_load_drop", alu_load, 0);

    // memory write acked after 3 wait cycles -> mem_req high 4 cycles
    offer(2'b11, 8'h99, 8'h40);
    tick();
    in_valid = 1'b0;
    check("mem_req_start", mem_req, 1);
    check("mem_busy_start", busy, 1);
    check("mem_addr", mem_addr, 8'h40);
    check("mem_wdata", mem_wdata, 8'h99);
    check("mem_ready_low", in_ready, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("mem_req_hold", {mem_req, in_ready, mem_err}, 3'b100);
      check("mem_addr_data_hold", {mem_addr, mem_wdata}, 16'h4099);
    end
    mem_ack = 1'b1;
    offer(2'b00, 8'h5A, 8'h00);
    tick();
    check("ack_mem_req", mem_req, 0);
    check("ack_busy", busy, 0);
    check("ack_no_err", mem_err, 0);
    check("ack_not_taken", alu_load, 0);
    check("ack_ready", in_ready, 1);
    tick();
    mem_ack = 1'b0;
    in_valid = 1'b0;
    check("post_ack_xfer", alu_opnd, 8'h5A);
    check("post_ack_load", alu_load, 1);
    check("idle_ack_ignored", mem_req, 0);

    // timeout: no ack, abort after 15 wait cycles
    offer(2'b11, 8'h77, 8'h12);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("to_req_hold", {mem_req, mem_err, busy}, 3'b101);
    end
    tick();
    check("to_req_drop", mem_req, 0);
    check("to_err", mem_err, 1);
    check("to_busy", busy, 0);
    check("to_ready", in_ready, 1);
    check("to_regs_kept", {alu_opnd, rem_reg, bus1_data}, 24'h5A05A7);
    tick();
    check("to_err_pulse", mem_err, 0);

    // ack exactly on the expiry edge: normal completion
    offer(2'b11, 8'h66, 8'h21);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    check("exp_req_before", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("exp_req_drop", mem_req, 0);
    check("exp_no_err", mem_err, 0);
    tick();
    check("exp_no_err_late", mem_err, 0);
    check("exp_ready", in_ready, 1);

    // reset during the second MEM_WAIT cycle
    offer(2'b11, 8'h33, 8'h44);
    tick();
    in_valid = 1'b0;
    tick();
    check("rmw_req_high", mem_req, 1);
    reset = 1'b1;
    tick();
    check("rmw_req", mem_req, 0);
    check("rmw_err", mem_err, 0);
    check("rmw_busy", busy, 0);
    check("rmw_regs", {alu_opnd, rem_reg, bus1_data, mem_addr, mem_wdata}, 40'h0);
    reset = 1'b0;
    tick();
    check("rmw_ready", in_ready, 1);
    check("rmw_err_after", mem_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
